// File: rtl/spi_ctrl_pkg.sv
// ============================================================================
// spi_ctrl_pkg : shared codes, state encoding and address helper for spi_frame_ctrl
// Revision     : 1.0
// ============================================================================
`default_nettype none

package spi_ctrl_pkg;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] CMD_SELECT  = 8'h03;

    localparam logic [7:0] STATUS_ADDR = 8'h00;

    typedef enum logic [1:0] {
        DEV_NONE  = 2'd0,
        DEV_COMP1 = 2'd1,
        DEV_COMP2 = 2'd2,
        DEV_RELAY = 2'd3
    } dev_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ARG     = 3'd2,
        ST_EXEC    = 3'd3,
        ST_HOLD    = 3'd4,
        ST_PASS    = 3'd5,
        ST_RLY_RST = 3'd6
    } state_e;

    // True when addr names one of the writable select registers (1..num_regs).
    function automatic logic reg_addr_ok(input logic [7:0] addr, input int unsigned num_regs);
        return (addr != STATUS_ADDR) && (32'(addr) <= num_regs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_frame_ctrl_pulse_timer.sv
// ============================================================================
// pulse_timer : loadable down-counter; done_o is high once the count reaches 0
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pulse_timer #(
    parameter int CYCLES = 48
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt_q;

    // Loading CYCLES-1 makes the owner's output high for exactly CYCLES clocks.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= W'(CYCLES - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/spi_frame_ctrl.sv
// ============================================================================
// spi_frame_ctrl : decodes two-byte host frames, owns select registers,
//                  read-back staging, device chip selects and relay reset pulse
// Revision       : 1.0
// ============================================================================
`default_nettype none

module spi_frame_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int RLY_RST_CYCLES = 48,
    parameter int NUM_REGS       = 5
) (
    input  logic       clk_12mhz,
    input  logic       rst,
    input  logic       cs_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic [3:0] input_sel,
    output logic [3:0] mu_sel,
    output logic [3:0] avk_sel,
    output logic [3:0] fil1_sel,
    output logic [3:0] fil2_sel,
    output logic       comp1_cs,
    output logic       comp2_cs,
    output logic       relay_cs,
    output logic       pass_en,
    output logic       relay_reset,
    output logic       err
);

    localparam int REG_DEPTH = (NUM_REGS > 5) ? NUM_REGS : 5;

    state_e     state_q;
    dev_e       dev_pend_q;
    logic       cs_prev_q;
    logic [7:0] cmd_q;
    logic [7:0] arg_q;
    logic [7:0] tx_byte_q;
    logic       tx_load_q;
    logic       pass_en_q;
    logic       relay_reset_q;
    logic       err_q;
    logic [3:0] regs_q [1:REG_DEPTH];

    logic       cs_rise;
    logic       wr_ok_d;
    logic       rd_hit_d;
    logic [7:0] rd_byte_d;
    logic       timer_load;
    logic       timer_done;

    assign cs_rise = cs_active && !cs_prev_q;
    assign wr_ok_d = reg_addr_ok({4'b0, arg_q[7:4]}, NUM_REGS);

    always_comb begin
        rd_byte_d = 8'hFF;
        rd_hit_d  = 1'b0;
        if (arg_q == STATUS_ADDR) begin
            rd_byte_d = {7'b0, err_q};
            rd_hit_d  = 1'b1;
        end
        for (int i = 1; i <= NUM_REGS; i++) begin
            if (arg_q == 8'(i)) begin
                rd_byte_d = {4'b0, regs_q[i]};
                rd_hit_d  = 1'b1;
            end
        end
    end

    assign timer_load = (state_q == ST_PASS) && !cs_active && (dev_pend_q == DEV_RELAY);

    pulse_timer #(
        .CYCLES (RLY_RST_CYCLES)
    ) u_rly_timer (
        .clk_i  (clk_12mhz),
        .rst_ni (rst),
        .load_i (timer_load),
        .en_i   (state_q == ST_RLY_RST),
        .done_o (timer_done)
    );

    always_ff @(posedge clk_12mhz) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            dev_pend_q    <= DEV_NONE;
            // A frame already open when reset releases is not a fresh frame.
            cs_prev_q     <= 1'b1;
            cmd_q         <= 8'h00;
            arg_q         <= 8'h00;
            tx_byte_q     <= 8'h00;
            tx_load_q     <= 1'b0;
            pass_en_q     <= 1'b0;
            relay_reset_q <= 1'b0;
            err_q         <= 1'b0;
            for (int i = 1; i <= REG_DEPTH; i++) begin
                regs_q[i] <= 4'h0;
            end
        end else begin
            cs_prev_q <= cs_active;
            tx_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_rise) begin
                        if (dev_pend_q != DEV_NONE) begin
                            state_q   <= ST_PASS;
                            pass_en_q <= 1'b1;
                        end else begin
                            state_q <= ST_CMD;
                        end
                    end
                end
                ST_CMD: begin
                    if (!cs_active) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (rx_valid) begin
                        cmd_q   <= rx_byte;
                        state_q <= ST_ARG;
                    end
                end
                ST_ARG: begin
                    if (!cs_active) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (rx_valid) begin
                        arg_q   <= rx_byte;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_HOLD;
                    case (cmd_q)
                        CMD_WRITE: begin
                            if (wr_ok_d) begin
                                for (int i = 1; i <= NUM_REGS; i++) begin
                                    if (arg_q[7:4] == 4'(i)) begin
                                        regs_q[i] <= arg_q[3:0];
                                    end
                                end
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        CMD_READ: begin
                            tx_load_q <= 1'b1;
                            tx_byte_q <= rd_byte_d;
                            if (arg_q == STATUS_ADDR) begin
                                err_q <= 1'b0;
                            end else if (!rd_hit_d) begin
                                err_q <= 1'b1;
                            end
                        end
                        CMD_SELECT: begin
                            if ((arg_q >= 8'd1) && (arg_q <= 8'd3)) begin
                                dev_pend_q <= dev_e'(arg_q[1:0]);
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        default: err_q <= 1'b1;
                    endcase
                end
                ST_HOLD: begin
                    if (!cs_active) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PASS: begin
                    if (!cs_active) begin
                        dev_pend_q <= DEV_NONE;
                        pass_en_q  <= 1'b0;
                        if (dev_pend_q == DEV_RELAY) begin
                            state_q       <= ST_RLY_RST;
                            relay_reset_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_RLY_RST: begin
                    if (timer_done) begin
                        relay_reset_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Chip selects follow the host CS directly so the device sees the host's exact frame edges.
    assign comp1_cs = !((state_q == ST_PASS) && (dev_pend_q == DEV_COMP1) && cs_active);
    assign comp2_cs = !((state_q == ST_PASS) && (dev_pend_q == DEV_COMP2) && cs_active);
    assign relay_cs = !((state_q == ST_PASS) && (dev_pend_q == DEV_RELAY) && cs_active);

    assign tx_byte     = tx_byte_q;
    assign tx_load     = tx_load_q;
    assign pass_en     = pass_en_q;
    assign relay_reset = relay_reset_q;
    assign err         = err_q;
    assign input_sel   = regs_q[1];
    assign mu_sel      = regs_q[2];
    assign avk_sel     = regs_q[3];
    assign fil1_sel    = regs_q[4];
    assign fil2_sel    = regs_q[5];

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_ctrl.sv
// ============================================================================
// tb_spi_frame_ctrl : table vectors, corner sequences and random frames vs a model
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_frame_ctrl;

    localparam int RLY = 48;

    logic       clk_12mhz = 1'b0;
    logic       rst;
    logic       cs_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [3:0] input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel;
    logic       comp1_cs, comp2_cs, relay_cs, pass_en, relay_reset, err;

    always #5 clk_12mhz = ~clk_12mhz;

    spi_frame_ctrl #(
        .RLY_RST_CYCLES (RLY),
        .NUM_REGS       (5)
    ) dut (
        .clk_12mhz   (clk_12mhz),
        .rst         (rst),
        .cs_active   (cs_active),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_byte     (tx_byte),
        .tx_load     (tx_load),
        .input_sel   (input_sel),
        .mu_sel      (mu_sel),
        .avk_sel     (avk_sel),
        .fil1_sel    (fil1_sel),
        .fil2_sel    (fil2_sel),
        .comp1_cs    (comp1_cs),
        .comp2_cs    (comp2_cs),
        .relay_cs    (relay_cs),
        .pass_en     (pass_en),
        .relay_reset (relay_reset),
        .err         (err)
    );

    int n_pass  = 0;
    int n_total = 0;
    int load_cnt = 0;
    int rly_cnt  = 0;

    always @(negedge clk_12mhz) begin
        if (tx_load === 1'b1)     load_cnt++;
        if (relay_reset === 1'b1) rly_cnt++;
    end

    // Behavioural model of the host-visible state.
    logic [3:0] m_regs [1:5];
    logic       m_err;
    logic [7:0] m_tx;
    int         m_dev;

    typedef struct {
        logic [7:0] c;
        logic [7:0] a;
        int         nb;
        logic       exp_err;
        int         exp_loads;
        logic [7:0] exp_tx;
        int         ridx;
        logic [3:0] rval;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_12mhz);
        #1;
    endtask

    function automatic logic [3:0] get_reg(input int idx);
        case (idx)
            1: return input_sel;
            2: return mu_sel;
            3: return avk_sel;
            4: return fil1_sel;
            default: return fil2_sel;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 5; i++) m_regs[i] = 4'h0;
        m_err = 1'b0;
        m_tx  = 8'h00;
        m_dev = 0;
    endtask

    task automatic model_frame(input logic [7:0] c, input logic [7:0] a, input int nb, output int loads);
        loads = 0;
        if (nb < 2) begin
            m_err = 1'b1;
        end else if (c == 8'h01) begin
            if (a[7:4] >= 4'd1 && a[7:4] <= 4'd5) m_regs[int'(a[7:4])] = a[3:0];
            else m_err = 1'b1;
        end else if (c == 8'h02) begin
            loads = 1;
            if (a == 8'h00) begin
                m_tx  = {7'b0, m_err};
                m_err = 1'b0;
            end else if (a <= 8'd5) begin
                m_tx = {4'b0, m_regs[int'(a)]};
            end else begin
                m_tx  = 8'hFF;
                m_err = 1'b1;
            end
        end else if (c == 8'h03) begin
            if (a >= 8'd1 && a <= 8'd3) m_dev = int'(a);
            else m_err = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        repeat (9) tick();
    endtask

    task automatic host_frame(input logic [7:0] c, input logic [7:0] a, input int nb);
        cs_active = 1'b1;
        tick();
        tick();
        if (nb >= 1) send_byte(c);
        if (nb >= 2) send_byte(a);
        cs_active = 1'b0;
        tick();
        tick();
    endtask

    task automatic compare_all(input string tag, input int exp_loads, input int base);
        check({tag, " err"}, 32'(err), 32'(m_err));
        check({tag, " tx_byte"}, 32'(tx_byte), 32'(m_tx));
        check({tag, " regs"}, 32'({input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel}),
              32'({m_regs[1], m_regs[2], m_regs[3], m_regs[4], m_regs[5]}));
        check({tag, " tx_load pulses"}, 32'(load_cnt - base), 32'(exp_loads));
        check({tag, " idle pins"}, 32'({comp1_cs, comp2_cs, relay_cs, pass_en, relay_reset}), 32'(5'b11100));
    endtask

    task automatic run_frame(input logic [7:0] c, input logic [7:0] a, input int nb, input string tag);
        int base;
        int loads;
        base = load_cnt;
        host_frame(c, a, nb);
        model_frame(c, a, nb, loads);
        compare_all(tag, loads, base);
    endtask

    // Routed frame to the pending device; optionally opens a host frame during the relay pulse.
    task automatic pass_frame(input bit open_in_pulse);
        int         d;
        int         rbase;
        int         k;
        logic [2:0] exp_pins;
        d = m_dev;
        exp_pins = (d == 1) ? 3'b011 : (d == 2) ? 3'b101 : 3'b110;
        rbase = rly_cnt;
        cs_active = 1'b1;
        tick();
        check("pass cs open", 32'({comp1_cs, comp2_cs, relay_cs}), 32'(exp_pins));
        check("pass_en", 32'(pass_en), 32'd1);
        send_byte(8'h01);
        send_byte(8'h1F);
        check("pass cs held", 32'({comp1_cs, comp2_cs, relay_cs}), 32'(exp_pins));
        cs_active = 1'b0;
        #1;
        check("pass cs close", 32'({comp1_cs, comp2_cs, relay_cs}), 32'(3'b111));
        tick();
        m_dev = 0;
        if (d == 3) begin
            k = 0;
            if (open_in_pulse) begin
                repeat (5) tick();
                cs_active = 1'b1;
                send_byte(8'h01);
                k = 15;
            end
            while (relay_reset === 1'b1 && k < 200) begin
                tick();
                k++;
            end
            tick();
            if (open_in_pulse) begin
                send_byte(8'h01);
                send_byte(8'h1F);
                cs_active = 1'b0;
                tick();
                tick();
            end
        end else begin
            tick();
        end
        check("relay pulse len", 32'(rly_cnt - rbase), (d == 3) ? 32'(RLY) : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int base;
        int loads;
        int r;
        logic [7:0] c;
        logic [7:0] a;
        int nb;

        tbl[0]  = '{8'h01, 8'h13, 2, 1'b0, 0, 8'h00, 1, 4'h3};
        tbl[1]  = '{8'h01, 8'h5F, 2, 1'b0, 0, 8'h00, 5, 4'hF};
        tbl[2]  = '{8'h01, 8'h2A, 2, 1'b0, 0, 8'h00, 2, 4'hA};
        tbl[3]  = '{8'h02, 8'h02, 2, 1'b0, 1, 8'h0A, 2, 4'hA};
        tbl[4]  = '{8'h02, 8'h09, 2, 1'b1, 1, 8'hFF, 1, 4'h3};
        tbl[5]  = '{8'h02, 8'h00, 2, 1'b0, 1, 8'h01, 1, 4'h3};
        tbl[6]  = '{8'h01, 8'h00, 1, 1'b1, 0, 8'h01, 1, 4'h3};
        tbl[7]  = '{8'h02, 8'h00, 2, 1'b0, 1, 8'h01, 1, 4'h3};
        tbl[8]  = '{8'h7E, 8'h00, 2, 1'b1, 0, 8'h01, 1, 4'h3};
        tbl[9]  = '{8'h02, 8'h00, 2, 1'b0, 1, 8'h01, 1, 4'h3};
        tbl[10] = '{8'h01, 8'h63, 2, 1'b1, 0, 8'h01, 1, 4'h3};
        tbl[11] = '{8'h02, 8'h00, 2, 1'b0, 1, 8'h01, 1, 4'h3};
        tbl[12] = '{8'h03, 8'h07, 2, 1'b1, 0, 8'h01, 5, 4'hF};
        tbl[13] = '{8'h02, 8'h05, 2, 1'b1, 1, 8'h0F, 5, 4'hF};

        rst       = 1'b0;
        cs_active = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        model_reset();
        repeat (3) tick();
        check("reset regs", 32'({input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel}), 32'd0);
        check("reset tx", 32'({tx_byte, tx_load, err}), 32'd0);
        check("reset pins", 32'({comp1_cs, comp2_cs, relay_cs, pass_en, relay_reset}), 32'(5'b11100));
        rst = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 14; i++) begin
            base = load_cnt;
            host_frame(tbl[i].c, tbl[i].a, tbl[i].nb);
            model_frame(tbl[i].c, tbl[i].a, tbl[i].nb, loads);
            check($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d loads", i), 32'(load_cnt - base), 32'(tbl[i].exp_loads));
            check($sformatf("vec%0d tx_byte", i), 32'(tx_byte), 32'(tbl[i].exp_tx));
            check($sformatf("vec%0d reg%0d", i, tbl[i].ridx), 32'(get_reg(tbl[i].ridx)), 32'(tbl[i].rval));
        end

        // Write latency: register changes on the second edge after the argument strobe.
        cs_active = 1'b1;
        tick(); tick();
        send_byte(8'h01);
        rx_valid = 1'b1; rx_byte = 8'h4C;
        tick();
        rx_valid = 1'b0;
        check("write lat +1", 32'(fil1_sel), 32'(m_regs[4]));
        tick();
        check("write lat +2", 32'(fil1_sel), 32'h C);
        repeat (8) tick();
        cs_active = 1'b0;
        tick(); tick();
        model_frame(8'h01, 8'h4C, 2, loads);

        // Read latency and single-cycle tx_load.
        cs_active = 1'b1;
        tick(); tick();
        send_byte(8'h02);
        rx_valid = 1'b1; rx_byte = 8'h04;
        tick();
        rx_valid = 1'b0;
        check("read lat +1 load", 32'(tx_load), 32'd0);
        tick();
        check("read lat +2 load", 32'({tx_load, tx_byte}), 32'({1'b1, 8'h0C}));
        tick();
        check("read lat +3 load", 32'(tx_load), 32'd0);
        repeat (7) tick();
        cs_active = 1'b0;
        tick(); tick();
        model_frame(8'h02, 8'h04, 2, loads);

        run_frame(8'h03, 8'h02, 2, "sel comp2");
        pass_frame(1'b0);
        run_frame(8'h01, 8'h11, 2, "after comp2");

        run_frame(8'h03, 8'h03, 2, "sel relay");
        pass_frame(1'b1);
        check("ignored frame reg", 32'(input_sel), 32'(m_regs[1]));
        run_frame(8'h01, 8'h17, 2, "after relay");

        for (int it = 0; it < 40; it++) begin
            if (m_dev != 0) begin
                base = load_cnt;
                pass_frame(1'b0);
                compare_all($sformatf("rnd%0d pass", it), 0, base);
                continue;
            end
            r  = $urandom_range(0, 9);
            nb = 2;
            a  = 8'($urandom_range(0, 255));
            if (r <= 3) begin
                c = 8'h01;
                a[7:4] = 4'($urandom_range(0, 7));
            end else if (r <= 6) begin
                c = 8'h02;
                a = 8'($urandom_range(0, 7));
            end else if (r == 7) begin
                c = 8'h03;
                a = 8'($urandom_range(0, 4));
            end else if (r == 8) begin
                c = 8'($urandom_range(4, 255));
            end else begin
                c  = 8'h01;
                nb = $urandom_range(0, 1);
            end
            run_frame(c, a, nb, $sformatf("rnd%0d c%0h a%0h", it, c, a));
        end
        if (m_dev != 0) pass_frame(1'b0);

        // Reset while routing a frame to comp1.
        run_frame(8'h03, 8'h01, 2, "sel comp1");
        cs_active = 1'b1;
        tick(); tick();
        check("mid-pass comp1", 32'({comp1_cs, comp2_cs, relay_cs}), 32'(3'b011));
        rst = 1'b0;
        tick();
        check("rst pass pins", 32'({comp1_cs, comp2_cs, relay_cs, pass_en, relay_reset}), 32'(5'b11100));
        check("rst pass regs", 32'({input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel, err}), 32'd0);
        rst = 1'b1;
        cs_active = 1'b0;
        tick(); tick();
        model_reset();
        run_frame(8'h01, 8'h31, 2, "after pass rst");

        // Reset during the relay pulse.
        run_frame(8'h03, 8'h03, 2, "sel relay2");
        cs_active = 1'b1;
        tick(); tick();
        cs_active = 1'b0;
        repeat (10) tick();
        check("pulse active", 32'(relay_reset), 32'd1);
        rst = 1'b0;
        tick();
        check("rst pulse pins", 32'({comp1_cs, comp2_cs, relay_cs, pass_en, relay_reset}), 32'(5'b11100));
        rst = 1'b1;
        tick();
        model_reset();
        run_frame(8'h01, 8'h48, 2, "after pulse rst");
        run_frame(8'h02, 8'h04, 2, "readback");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

Command sequencer between the SPI byte receiver and the analog front-end control outputs in `top`. It decodes two-byte host frames (command, argument) and does three things: writes the front-end select registers, stages read-back bytes for MISO, and routes the next SPI frame to one of the downstream SPI devices (comp1, comp2, relay). It owns every chip-select and `relay_reset` decision. Everything runs in the `clk_12mhz` domain.

## Interface
Parameters:
- `RLY_RST_CYCLES`, default 48: length of the `relay_reset` pulse in clocks (4 µs).
- `NUM_REGS`, default 5: number of writable 4-bit select registers, addresses 1..NUM_REGS.

Ports (clock and reset first):
- `clk_12mhz`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `cs_active`  in  1  synchronized level of host `spi_cs`; 1 means the frame is open.
- `rx_valid`  in  1  one-cycle strobe: a received byte is on `rx_byte`.
- `rx_byte`  in  8  received byte, MSB first as shifted.
- `tx_byte`  out  8  byte for the SPI transmitter.
- `tx_load`  out  1  one-cycle strobe: load `tx_byte`.
- `input_sel`, `mu_sel`, `avk_sel`, `fil1_sel`, `fil2_sel`  out  4 each  config registers 1..5.
- `comp1_cs`, `comp2_cs`, `relay_cs`  out  1 each  device chip selects, active low.
- `pass_en`  out  1  high while a device frame is routed (MISO mux select).
- `relay_reset`  out  1  active-high reset pulse to the relay driver.
- `err`  out  1  sticky error flag.

## Operation
- States: IDLE, CMD, ARG, EXEC, HOLD, PASS, RLY_RST.
- IDLE:
  - `cs_active` rises and `dev_pend` is 0 → CMD.
  - `cs_active` rises and `dev_pend` is nonzero → PASS.
- CMD: the first `rx_valid` latches `cmd` → ARG.
- ARG: the first `rx_valid` latches `arg` → EXEC.
- EXEC lasts one cycle, then → HOLD. Action by command:
  - 0x01 WRITE: `addr = arg[7:4]`, `val = arg[3:0]`. For addr 1..NUM_REGS, write the register; any other addr sets `err`.
  - 0x02 READ: `addr = arg[7:0]`. Addr 0 returns `{7'b0, err}` and clears `err` in the same cycle. Addr 1..NUM_REGS returns `{4'b0, reg}`. Any other addr returns 0xFF and sets `err`. Assert `tx_load`.
  - 0x03 SELECT: `arg` 1/2/3 sets `dev_pend` to comp1/comp2/relay. Any other value sets `err`.
  - Any other command sets `err`; no other effect.
- HOLD: further bytes are ignored. `cs_active` low → IDLE.
- PASS:
  - The selected `*_cs` equals `~cs_active`, combinationally from the registered state; all other chip selects stay 1.
  - `pass_en` is 1.
  - `rx_valid` is ignored; no register writes.
  - `cs_active` low: `dev_pend` clears. If the device was relay → RLY_RST, otherwise → IDLE.
- RLY_RST: `relay_reset` is 1 for exactly RLY_RST_CYCLES clocks, then → IDLE. A host frame opening during the pulse waits until IDLE is re-entered; a frame already open on return is not decoded and is ignored until it closes.
- Short frame: `cs_active` falls in CMD or ARG → IDLE, sets `err`, no register change.
- Reset (`rst` low at a clock edge), including mid-PASS or mid-pulse:
  - state IDLE.
  - all selects 0; `tx_byte` 0x00.
  - `comp1_cs`/`comp2_cs`/`relay_cs` 1.
  - `relay_reset`, `pass_en`, `tx_load`, `err`, `dev_pend` 0.

## Timing
- Every output is registered, except the `*_cs` gating by `cs_active` in PASS, which is the only combinational path.
- Latency from the argument `rx_valid` edge: register write, `tx_load`, and `dev_pend` update are visible 2 clocks later (ARG→EXEC, then the EXEC edge).
- `tx_load` is exactly one cycle wide. `tx_byte` stays stable until the next `tx_load` or reset.
- A chip select never asserts outside PASS; device routing always takes effect on the frame after SELECT, never the current one.
- `rx_valid` arriving on the same edge as `cs_active` falling is ignored; the frame is treated as closed first.
- `rx_valid` strobes are assumed at least 8 clocks apart; the block need not handle back-to-back strobes.

## Structure
- Shared package `spi_ctrl_pkg`:
  - command codes CMD_WRITE=0x01, CMD_READ=0x02, CMD_SELECT=0x03.
  - device codes DEV_NONE=0, DEV_COMP1=1, DEV_COMP2=2, DEV_RELAY=3.
  - state enum.
  - status address 0.
- Sub-module `pulse_timer`: loadable down-counter sized by RLY_RST_CYCLES, used for RLY_RST.
- Register file and FSM stay in the top of this block.

## Test plan
- Frame 0x01,0x13 → `input_sel`=3 two clocks after the second `rx_valid`; `err` stays 0. Frame 0x01,0x5F → `fil2_sel`=0xF.
- Write 0x01,0x2A, then frame 0x02,0x02 → `tx_load` single pulse with `tx_byte`=0x0A. Frame 0x02,0x09 → `tx_byte`=0xFF, `err`=1. Frame 0x02,0x00 → `tx_byte`=0x01, then `err`=0.
- Frame 0x03,0x02, close, reopen → `comp2_cs` low exactly while `cs_active`; `comp1_cs`/`relay_cs` stay 1; `pass_en`=1. Next frame decodes normally.
- Frame 0x03,0x03, then a relay frame → on close, `relay_reset` high for 48 clocks. A host frame opened during the pulse is ignored until IDLE is re-entered; a frame started after that decodes normally.
- Close `cs_active` after one byte (0x01) → no register change, `err`=1. Unknown command 0x7E → `err`=1.
- Assert `rst` low mid-PASS and mid-pulse → next clock: all chip selects 1, `relay_reset` 0, registers 0, state IDLE.
